// File: rtl/ex_div.sv
// -----------------------------------------------------------------------------
// ex_div -- multi-cycle integer divide unit for the execute stage.
//
// Implements MIPS DIV (signed) and DIVU (unsigned) as a 32-step restoring
// division. The quotient is returned on lo and the remainder on hi. While a
// divide is in flight the unit asks the stall controller to freeze the
// front of the pipeline through stallreq.
//
// Ports:
//   clk            pipeline clock (shared with ID/EX)
//   rst            synchronous, active-high reset
//   ex_aluop [7:0] operation code from ID/EX
//   ex_reg1 [31:0] dividend (rs)
//   ex_reg2 [31:0] divisor (rt)
//   annul          flush; abandons a divide in progress
//   hold           downstream stall; keeps the unit in END
//   stallreq       combinational freeze request for PC..ID/EX
//   hi [31:0]      remainder
//   lo [31:0]      quotient
//   done           hi/lo valid and to be written this cycle
//   div_stall_cnt  [31:0] cycles with stallreq high (only with the macro)
//
// Optional feature macro: DIV_STALL_CNT_EN
//   When defined, adds the div_stall_cnt output, a free-running wrap-around
//   counter of cycles in which stallreq was asserted.
// -----------------------------------------------------------------------------
module ex_div #(
    parameter logic [7:0] DIV_OP  = 8'b00011010,
    parameter logic [7:0] DIVU_OP = 8'b00011011,
    parameter int         ITER    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_reg1,
    input  logic [31:0] ex_reg2,
    input  logic        annul,
    input  logic        hold,
    output logic        stallreq,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done
`ifdef DIV_STALL_CNT_EN
    ,
    output logic [31:0] div_stall_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    localparam logic [5:0] LAST_CNT = 6'(ITER - 1);

    state_t      state_q, state_d;
    logic [64:0] work_q, work_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] divisor_q, divisor_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    // -------------------------------------------------------------------------
    // Operand decode
    // -------------------------------------------------------------------------
    logic        is_div;
    logic        is_signed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    assign is_div    = (ex_aluop == DIV_OP) || (ex_aluop == DIVU_OP);
    assign is_signed = (ex_aluop == DIV_OP);
    // -2^31 maps onto itself, which read as unsigned is exactly |-2^31|.
    assign abs_a     = (is_signed && ex_reg1[31]) ? (32'd0 - ex_reg1) : ex_reg1;
    assign abs_b     = (is_signed && ex_reg2[31]) ? (32'd0 - ex_reg2) : ex_reg2;

    // -------------------------------------------------------------------------
    // One restoring-division step.
    // The partial remainder lives in [64:32], the dividend/quotient in [31:0].
    // After the shift the upper field is below 2*divisor, so a 33-bit trial
    // subtraction is enough: bit 32 of the result is the borrow.
    // -------------------------------------------------------------------------
    logic [64:0] shifted;
    logic [32:0] trial;
    logic [64:0] iter_next;
    logic [31:0] quot_raw;
    logic [31:0] rem_raw;

    assign shifted   = {work_q[63:0], 1'b0};
    assign trial     = shifted[64:32] - {1'b0, divisor_q};
    assign iter_next = trial[32] ? shifted : {trial, shifted[31:1], 1'b1};
    assign quot_raw  = iter_next[31:0];
    assign rem_raw   = iter_next[63:32];

    // The top bit of the working register is always zero once a step has
    // completed; it is kept only so the register mirrors the 65-bit layout.
    logic unused_msb;
    assign unused_msb = work_q[64] ^ iter_next[64];

    // -------------------------------------------------------------------------
    // Stall request: a divide is waiting or in flight and not being flushed.
    // -------------------------------------------------------------------------
    assign stallreq = is_div && (state_q != S_END) && !annul;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            S_IDLE: begin
                if (is_div && !annul) begin
                    if (ex_reg2 == 32'd0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d    = S_ON;
                        divisor_d  = abs_b;
                        neg_quot_d = is_signed && (ex_reg1[31] ^ ex_reg2[31]);
                        neg_rem_d  = is_signed && ex_reg1[31];
                        work_d     = {33'd0, abs_a};
                        cnt_d      = 6'd0;
                    end
                end
            end

            S_BYZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    // Architecturally undefined; fixed to zero here.
                    state_d = S_END;
                    hi_d    = 32'd0;
                    lo_d    = 32'd0;
                end
            end

            S_ON: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    work_d = iter_next;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_END;
                        lo_d    = neg_quot_q ? (32'd0 - quot_raw) : quot_raw;
                        hi_d    = neg_rem_q  ? (32'd0 - rem_raw)  : rem_raw;
                    end
                end
            end

            S_END: begin
                // Result is committed; annul has no effect here.
                if (!hold) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= 65'd0;
            cnt_q      <= 6'd0;
            divisor_q  <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = (state_q == S_END);

`ifdef DIV_STALL_CNT_EN
    // -------------------------------------------------------------------------
    // Stall-cycle counter; wraps naturally at 32 bits.
    // -------------------------------------------------------------------------
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stallreq) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign div_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_div.sv
// -----------------------------------------------------------------------------
// tb_ex_div -- directed self-checking bench for ex_div.
// Inputs change 1 time unit after the rising edge; outputs are checked a
// further time unit later, well away from the next rising edge.
// -----------------------------------------------------------------------------
module tb_ex_div;

    localparam logic [7:0] DIV_OP  = 8'b00011010;
    localparam logic [7:0] DIVU_OP = 8'b00011011;

    logic        clk;
    logic        rst;
    logic [7:0]  ex_aluop;
    logic [31:0] ex_reg1;
    logic [31:0] ex_reg2;
    logic        annul;
    logic        hold;
    logic        stallreq;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
`ifdef DIV_STALL_CNT_EN
    logic [31:0] div_stall_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    ex_div dut (
        .clk      (clk),
        .rst      (rst),
        .ex_aluop (ex_aluop),
        .ex_reg1  (ex_reg1),
        .ex_reg2  (ex_reg2),
        .annul    (annul),
        .hold     (hold),
        .stallreq (stallreq),
        .hi       (hi),
        .lo       (lo),
        .done     (done)
`ifdef DIV_STALL_CNT_EN
        ,
        .div_stall_cnt (div_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Runs one divide starting in an IDLE cycle. lat is the number of cycles
    // from accept to END; hold_cycles extra END cycles are requested via hold.
    task automatic do_div(input string name, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int lat, input int hold_cycles);
`ifdef DIV_STALL_CNT_EN
        logic [31:0] cnt0;
        cnt0 = div_stall_cnt;
`endif
        ex_aluop = op;
        ex_reg1  = a;
        ex_reg2  = b;
        #1;
        check({name, ":stall_c0"}, {31'd0, stallreq}, 32'd1);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            check({name, ":busy"}, {30'd0, done, stallreq}, 32'd1);
        end
        @(posedge clk); #1;
        check({name, ":end_done_stall"}, {30'd0, done, stallreq}, 32'd2);
        check({name, ":lo"}, lo, exp_lo);
        check({name, ":hi"}, hi, exp_hi);
`ifdef DIV_STALL_CNT_EN
        check({name, ":stall_cnt"}, div_stall_cnt - cnt0, 32'(lat));
`endif
        hold = (hold_cycles > 0);
        for (int k = 1; k <= hold_cycles; k++) begin
            @(posedge clk); #1;
            hold = (k < hold_cycles);
            check({name, ":hold_done"}, {31'd0, done}, 32'd1);
            check({name, ":hold_lo"}, lo, exp_lo);
            check({name, ":hold_hi"}, hi, exp_hi);
        end
        @(posedge clk); #1;
        ex_aluop = 8'h00;
        #1;
        check({name, ":idle_after"}, {30'd0, done, stallreq}, 32'd0);
        $display("tx %s op=%02h a=%08h b=%08h -> lo=%08h hi=%08h", name, op, a, b, lo, hi);
    endtask

    initial begin
        rst      = 1'b1;
        ex_aluop = 8'h00;
        ex_reg1  = 32'd0;
        ex_reg2  = 32'd0;
        annul    = 1'b0;
        hold     = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("reset:hi", hi, 32'd0);
        check("reset:lo", lo, 32'd0);
        check("reset:done_stall", {30'd0, done, stallreq}, 32'd0);
`ifdef DIV_STALL_CNT_EN
        check("reset:stall_cnt", div_stall_cnt, 32'd0);
`endif
        $display("tx reset");

        // Basic divides, back to back
        do_div("divu_100_7",  DIVU_OP, 32'd100,      32'd7,          32'd14,        32'd2,        33, 0);
        do_div("div_m7_2",    DIV_OP,  32'hFFFFFFF9, 32'd2,          32'hFFFFFFFD,  32'hFFFFFFFF, 33, 0);
        do_div("div_7_m2",    DIV_OP,  32'd7,        32'hFFFFFFFE,   32'hFFFFFFFD,  32'd1,        33, 0);

        // Annul mid-divide: result registers must keep the previous values
        ex_aluop = DIVU_OP;
        ex_reg1  = 32'd1000;
        ex_reg2  = 32'd3;
        #1;
        check("annul:stall_c0", {31'd0, stallreq}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        #1;
        check("annul:stall_c10", {31'd0, stallreq}, 32'd0);
        @(posedge clk); #1;
        annul    = 1'b0;
        ex_aluop = 8'h00;
        #1;
        check("annul:c11_done_stall", {30'd0, done, stallreq}, 32'd0);
        check("annul:lo_kept", lo, 32'hFFFFFFFD);
        check("annul:hi_kept", hi, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
            check("annul:no_done", {31'd0, done}, 32'd0);
        end
        $display("tx annul divu 1000/3 at c10");

        do_div("divu_9_3",    DIVU_OP, 32'd9,        32'd3,          32'd3,         32'd0,        33, 0);
        do_div("div_min_m1",  DIV_OP,  32'h80000000, 32'hFFFFFFFF,   32'h80000000,  32'd0,        33, 0);
        do_div("divu_5_0",    DIVU_OP, 32'd5,        32'd0,          32'd0,         32'd0,        2,  0);
        do_div("divu_50_6_hold", DIVU_OP, 32'd50,    32'd6,          32'd8,         32'd2,        33, 3);

        // Reset in the middle of a divide
        ex_aluop = DIVU_OP;
        ex_reg1  = 32'd1000;
        ex_reg2  = 32'd3;
        #1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        ex_aluop = 8'h00;
        #1;
        check("midrst:hi", hi, 32'd0);
        check("midrst:lo", lo, 32'd0);
        check("midrst:done_stall", {30'd0, done, stallreq}, 32'd0);
        @(posedge clk); #1;
        check("midrst:still_idle", {31'd0, done}, 32'd0);
        $display("tx reset mid-divide");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
